// File: rtl/prbs31_pkg.sv
// Shared PRBS31 (x^31 + x^28 + 1) definitions for the generator and checker.
package prbs31_pkg;

  localparam int TAP_HI = 30;
  localparam int TAP_LO = 27;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } prbs31_state_e;

  function automatic logic prbs31_next(input logic [30:0] sr);
    return sr[TAP_HI] ^ sr[TAP_LO];
  endfunction

endpackage

// File: rtl/prbs31_checker_if.sv
// Serial stream in / lock and error status out for the PRBS31 checker.
interface prbs31_checker_if #(parameter int ERR_W = 16) ();
  logic             ena;
  logic             bit_in;
  logic             bit_valid;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       state;

  modport master (
    output ena, bit_in, bit_valid, clear,
    input  locked, err_pulse, err_count, state
  );

  modport slave (
    input  ena, bit_in, bit_valid, clear,
    output locked, err_pulse, err_count, state
  );
endinterface

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 checker with flywheel lock, error counting and loss-of-lock.
// state  | meaning
// SEARCH | shifting received bits into sr until 31 are loaded
// VERIFY | predicting from received bits, counting SYNC_BITS consecutive matches
// LOCKED | free-running prediction, received bits only compared
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int SYNC_BITS   = 32,
  parameter int WINDOW      = 256,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_W       = 16,
  parameter bit INVERT      = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  prbs31_checker_if.slave  bus
);

  localparam int WC_W = $clog2(WINDOW);
  localparam int WE_W = $clog2(LOSS_THRESH + 1);
  localparam int MT_W = $clog2(SYNC_BITS + 1);

  localparam logic [1:0] S_SEARCH = 2'(ST_SEARCH);
  localparam logic [1:0] S_VERIFY = 2'(ST_VERIFY);
  localparam logic [1:0] S_LOCKED = 2'(ST_LOCKED);

  logic [1:0]       state_q, state_d;
  logic [30:0]      sr_q, sr_d;
  logic [4:0]       fill_q, fill_d;
  logic [MT_W-1:0]  match_q, match_d;
  logic [WC_W-1:0]  win_cnt_q, win_cnt_d;
  logic [WE_W-1:0]  win_err_q, win_err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             err_pulse_q, err_pulse_d;

  logic        step, pred, exp_bit, bit_err, lose, win_wrap;
  logic [30:0] sr_shift;

  always_comb begin
    step     = bus.ena & bus.bit_valid;
    pred     = prbs31_next(sr_q);
    exp_bit  = pred ^ INVERT;
    bit_err  = bus.bit_in != exp_bit;
    sr_shift = {sr_q[29:0], bus.bit_in ^ INVERT};
    win_wrap = win_cnt_q == WC_W'(WINDOW - 1);
    lose     = 1'b0;

    state_d  = state_q;
    sr_d     = sr_q;
    fill_d   = fill_q;
    match_d  = match_q;

    if (step) begin
      case (state_q)
        S_SEARCH: begin
          sr_d = sr_shift;
          if (fill_q == 5'd30) begin
            state_d = S_VERIFY;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end
        S_VERIFY: begin
          sr_d = sr_shift;
          if (bit_err || sr_shift == '0) begin
            state_d = S_SEARCH;
            fill_d  = '0;
          end else begin
            match_d = match_q + MT_W'(1);
            if (match_q == MT_W'(SYNC_BITS - 1)) state_d = S_LOCKED;
          end
        end
        S_LOCKED: begin
          // Flywheel: only the prediction feeds back, so one bad bit gives one error.
          sr_d = {sr_q[29:0], pred};
          if (bit_err && win_err_q == WE_W'(LOSS_THRESH - 1)) begin
            lose    = 1'b1;
            state_d = S_SEARCH;
            fill_d  = '0;
          end
        end
        default: begin
          state_d = S_SEARCH;
          fill_d  = '0;
        end
      endcase
    end

    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    if (step && state_q == S_LOCKED) begin
      if (lose || win_wrap) begin
        win_cnt_d = '0;
        win_err_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + WC_W'(1);
        win_err_d = win_err_q + WE_W'(bit_err);
      end
    end

    err_pulse_d = step && state_q == S_LOCKED && bit_err;
    err_count_d = err_count_q;
    if (bus.ena && bus.clear)
      err_count_d = '0;
    else if (err_pulse_d && err_count_q != '1)
      err_count_d = err_count_q + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_SEARCH;
      sr_q    <= '0;
      fill_q  <= '0;
      match_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_cnt_q <= '0;
      win_err_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign bus.locked    = state_q == S_LOCKED;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_prbs31_checker.sv
// Scenario bench for prbs31_checker; err_pulse is scoreboarded every cycle.
module tb_prbs31_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prbs31_checker_if #(.ERR_W(16)) bus ();

  prbs31_checker #(
    .SYNC_BITS(32), .WINDOW(256), .LOSS_THRESH(8), .ERR_W(16), .INVERT(1'b0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [30:0] gsr;
  logic        exp_q[$];
  logic        mon_exp;
  logic        tb_locked = 1'b0;
  int          lsteps = 0;

  // One expectation per driven cycle; compared one delta after the edge.
  always @(posedge clk) begin
    if (exp_q.size() != 0) begin
      #1;
      mon_exp = exp_q.pop_front();
      tests_run++;
      if (bus.err_pulse !== mon_exp) begin
        tests_failed++;
        $display("FAIL err_pulse: got %b expected %b at t=%0t", bus.err_pulse, mon_exp, $time);
      end
    end
  end

  task automatic drive(input logic valid, input logic flip, input logic clr,
                       input logic en, input logic exp_pulse);
    logic b;
    if (valid && en) begin
      b   = gsr[30] ^ gsr[27];
      gsr = {gsr[29:0], b};
    end else begin
      b = 1'($urandom_range(0, 1));
    end
    bus.ena       = en;
    bus.bit_valid = valid;
    bus.bit_in    = b ^ flip;
    bus.clear     = clr;
    exp_q.push_back(exp_pulse);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic flip);
    drive(1'b1, flip, 1'b0, 1'b1, flip & tb_locked);
    if (tb_locked) lsteps++;
  endtask

  task automatic acquire();
    for (int i = 1; i <= 63; i++) begin
      send(1'b0);
      if (i == 31) begin
        tests_run++;
        if (bus.state !== 2'd1) begin
          tests_failed++;
          $display("FAIL acq_verify_state: got %0d expected 1", bus.state);
        end
      end
      if (i == 62) begin
        tests_run++;
        if (bus.locked !== 1'b0) begin
          tests_failed++;
          $display("FAIL acq_early_lock: got %b expected 0", bus.locked);
        end
      end
    end
    tests_run++;
    if (bus.locked !== 1'b1 || bus.state !== 2'd2) begin
      tests_failed++;
      $display("FAIL acq_lock: got locked=%b state=%0d expected 1/2", bus.locked, bus.state);
    end
    tb_locked = 1'b1;
    lsteps    = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (bus.locked !== 1'b0 || bus.state !== 2'd0 || bus.err_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got locked=%b state=%0d cnt=%0d expected 0/0/0",
               bus.locked, bus.state, bus.err_count);
    end
    rst_n     = 1'b1;
    gsr       = 31'h7FFF_FFFF;
    tb_locked = 1'b0;
  endtask

  task automatic test_clean();
    acquire();
    for (int i = 64; i <= 10000; i++) begin
      send(1'b0);
      if (i % 97 == 0) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    tests_run++;
    if (bus.err_count !== 16'd0 || bus.locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL clean_run: got cnt=%0d locked=%b expected 0/1", bus.err_count, bus.locked);
    end
  endtask

  task automatic test_single_error();
    for (int i = 1; i <= 1000; i++) begin
      send(i == 500);
      if (i == 500) begin
        tests_run++;
        if (bus.err_count !== 16'd1) begin
          tests_failed++;
          $display("FAIL single_cnt_now: got %0d expected 1", bus.err_count);
        end
      end
    end
    tests_run++;
    if (bus.err_count !== 16'd1 || bus.locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_end: got cnt=%0d locked=%b expected 1/1", bus.err_count, bus.locked);
    end
  endtask

  task automatic test_loss_of_lock();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (bus.err_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL loss_clear: got %0d expected 0", bus.err_count);
    end
    while (lsteps % 256 != 0) send(1'b0);
    for (int p = 0; p <= 80; p++) begin
      send(p >= 10 && p % 10 == 0);
      if (p == 70) begin
        tests_run++;
        if (bus.locked !== 1'b1) begin
          tests_failed++;
          $display("FAIL loss_seven_held: got %b expected 1", bus.locked);
        end
      end
    end
    tb_locked = 1'b0;
    tests_run++;
    if (bus.locked !== 1'b0 || bus.state !== 2'd0 || bus.err_count !== 16'd8) begin
      tests_failed++;
      $display("FAIL loss_drop: got locked=%b state=%0d cnt=%0d expected 0/0/8",
               bus.locked, bus.state, bus.err_count);
    end
    acquire();
  endtask

  task automatic test_two_windows();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int p = 0; p < 512; p++)
      send((p >= 100 && p <= 220 && p % 20 == 0) || (p >= 286 && p <= 406 && (p - 286) % 20 == 0));
    tests_run++;
    if (bus.locked !== 1'b1 || bus.err_count !== 16'd14) begin
      tests_failed++;
      $display("FAIL two_windows: got locked=%b cnt=%0d expected 1/14", bus.locked, bus.err_count);
    end
  endtask

  task automatic test_zeros();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n     = 1'b1;
    tb_locked = 1'b0;
    gsr       = 31'h0;
    for (int i = 1; i <= 224; i++) begin
      send(1'b0);
      tests_run++;
      if (bus.locked !== 1'b0) begin
        tests_failed++;
        $display("FAIL zeros_locked: got %b expected 0 at zero %0d", bus.locked, i);
      end
      if (i == 31 || i == 32) begin
        tests_run++;
        if (bus.state !== ((i == 31) ? 2'd1 : 2'd0)) begin
          tests_failed++;
          $display("FAIL zeros_state: got %0d at zero %0d", bus.state, i);
        end
      end
    end
    gsr = 31'h7FFF_FFFF;
    acquire();
  endtask

  task automatic test_reset_mid();
    send(1'b1);
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (bus.locked !== 1'b0 || bus.state !== 2'd0 || bus.err_count !== 16'd0 || bus.err_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: got locked=%b state=%0d cnt=%0d pulse=%b expected all 0",
               bus.locked, bus.state, bus.err_count, bus.err_pulse);
    end
    rst_n     = 1'b1;
    tb_locked = 1'b0;
    acquire();
  endtask

  task automatic test_clear_coincident();
    send(1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    lsteps++;
    tests_run++;
    if (bus.err_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL clear_priority: got %0d expected 0", bus.err_count);
    end
    send(1'b1);
    tests_run++;
    if (bus.err_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL clear_after: got %0d expected 1", bus.err_count);
    end
  endtask

  task automatic test_ena_hold();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (bus.state !== 2'd2 || bus.err_count !== 16'd1) begin
        tests_failed++;
        $display("FAIL ena_hold: got state=%0d cnt=%0d expected 2/1", bus.state, bus.err_count);
      end
    end
    for (int i = 0; i < 50; i++) send(1'b0);
    tests_run++;
    if (bus.locked !== 1'b1 || bus.err_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL ena_resume: got locked=%b cnt=%0d expected 1/1", bus.locked, bus.err_count);
    end
  endtask

  initial begin
    bus.ena       = 1'b1;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.clear     = 1'b0;
    gsr           = 31'h7FFF_FFFF;
    test_reset();
    test_clean();
    test_single_error();
    test_loss_of_lock();
    test_two_windows();
    test_zeros();
    test_reset_mid();
    test_clear_coincident();
    test_ena_hold();
    #3;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
